// File: rtl/vram_arbiter_pkg.sv
// Shared defaults and CPU-side state encoding for the video/CPU memory arbiter.
package vram_arbiter_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SLOT = 2'd1,
        READ_WAIT = 2'd2,
        ACK       = 2'd3
    } cpu_state_t;

    // A slot belongs to the CPU in phase 1, or in phase 0 when the video side is blanked.
    function automatic logic cpu_owns_slot(input logic phase, input logic video_blank);
        return phase | video_blank;
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Video, CPU and RAM signal bundle; the arbiter uses the slave view, its environment the master view.
interface vram_arbiter_if
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] video_address;
    logic              video_blank;
    logic [DATA_W-1:0] video_data;

    // CPU handshake: cpu_req is a level request, sampled only while the arbiter is idle;
    // cpu_busy covers the accepted transfer, cpu_ack pulses once at completion and
    // cpu_rdata is valid with that pulse and held afterwards.
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_busy;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  video_address, video_blank,
        input  cpu_req, cpu_we, cpu_address, cpu_wdata,
        input  mem_q,
        output video_data,
        output cpu_ack, cpu_rdata, cpu_busy,
        output mem_address, mem_wdata, mem_we
    );

    modport master (
        output video_address, video_blank,
        output cpu_req, cpu_we, cpu_address, cpu_wdata,
        output mem_q,
        input  video_data,
        input  cpu_ack, cpu_rdata, cpu_busy,
        input  mem_address, mem_wdata, mem_we
    );

endinterface

// File: rtl/vram_arbiter.sv
// Time-slot arbiter sharing one synchronous single-port RAM between a video scanout and a CPU.
// Even cycles serve video unless blanked; every other slot is offered to the CPU state machine.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic       clock,
    input  logic       reset,
    vram_arbiter_if.slave bus,
    output cpu_state_t state,
    output logic       phase
);

    cpu_state_t        state_next;
    logic              cpu_slot;
    logic              video_slot;
    logic              serve;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] wdata_hold;
    logic [ADDR_W-1:0] mem_address_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              mem_we_c;

    logic              video_pending;
    logic [DATA_W-1:0] video_data_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    assign cpu_slot   = cpu_owns_slot(phase, bus.video_blank);
    assign video_slot = ~cpu_slot;
    assign serve      = (state == WAIT_SLOT) && cpu_slot;

    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.cpu_req) state_next = WAIT_SLOT;
            WAIT_SLOT: if (cpu_slot) state_next = lat_we ? ACK : READ_WAIT;
            READ_WAIT: state_next = ACK;
            ACK:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if ((state == IDLE) && bus.cpu_req) begin
            lat_we    <= bus.cpu_we;
            lat_addr  <= bus.cpu_address;
            lat_wdata <= bus.cpu_wdata;
        end
    end

    // The RAM side is combinational so the slot owner reaches the RAM in its own cycle;
    // unused slots replay the last address so the RAM sees no spurious change.
    always_comb begin
        mem_address_c = addr_hold;
        mem_wdata_c   = wdata_hold;
        mem_we_c      = 1'b0;
        if (reset) begin
            mem_address_c = '0;
            mem_wdata_c   = '0;
        end else if (video_slot) begin
            mem_address_c = bus.video_address;
        end else if (serve) begin
            mem_address_c = lat_addr;
            if (lat_we) begin
                mem_wdata_c = lat_wdata;
                mem_we_c    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            addr_hold  <= mem_address_c;
            wdata_hold <= mem_wdata_c;
        end
    end

    // RAM data for a slot appears one cycle later, so both readers capture a cycle behind the slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            video_pending <= 1'b0;
            video_data_q  <= '0;
        end else begin
            video_pending <= video_slot;
            if (video_pending) begin
                video_data_q <= bus.mem_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rdata_q <= '0;
        end else if (state == READ_WAIT) begin
            cpu_rdata_q <= bus.mem_q;
        end
    end

    assign bus.mem_address = mem_address_c;
    assign bus.mem_wdata   = mem_wdata_c;
    assign bus.mem_we      = mem_we_c;
    assign bus.video_data  = video_data_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.cpu_ack     = (state == ACK) && !reset;
    assign bus.cpu_busy    = ((state == WAIT_SLOT) || (state == READ_WAIT)) && !reset;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: RAM model, timestamp-based reference model checked every cycle,
// and hand-computed expectations for the video, write, read, blanking, abort and boundary scenarios.
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    localparam int AW    = 14;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic       clock = 1'b0;
    logic       reset;
    cpu_state_t state;
    logic       phase;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .state (state),
        .phase (phase)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, want, $time);
        end
    endtask

    // ---------------- RAM (environment) ----------------
    logic [DW-1:0] ram [DEPTH];

    always @(posedge clock) begin
        bus.mem_q <= ram[bus.mem_address];
        if (bus.mem_we) ram[bus.mem_address] = bus.mem_wdata;
    end

    // ---------------- reference model ----------------
    logic          tb_phase = 1'b0;
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    logic          model_live = 1'b0;
    int            cyc = 0;
    logic          act = 1'b0;
    int            acc_cyc, ack_cyc;
    logic          svc_done;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [AW-1:0] e_addr  = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [DW-1:0] e_video = '0;
    logic [DW-1:0] e_rdata = '0;
    logic          vpend = 1'b0;
    logic [DW-1:0] vpend_val;

    int            ack_seen = 0;
    int            we_seen  = 0;
    logic [AW-1:0] last_we_addr  = '0;
    logic          last_we_phase = 1'b0;

    always @(posedge clock) tb_phase <= reset ? 1'b0 : ~tb_phase;

    always @(negedge clock) begin
        logic c_slot, v_slot, e_we, e_ack, e_busy;
        if (bus.cpu_ack) ack_seen++;
        if (bus.mem_we) begin
            we_seen++;
            last_we_addr  = bus.mem_address;
            last_we_phase = tb_phase;
        end
        if (reset) begin
            check("rst_cpu_ack", bus.cpu_ack, 1'b0);
            check("rst_cpu_busy", bus.cpu_busy, 1'b0);
            check("rst_mem_we", bus.mem_we, 1'b0);
            check("rst_mem_address", bus.mem_address, '0);
            check("rst_mem_wdata", bus.mem_wdata, '0);
            model_live = 1'b1;
            act = 1'b0; vpend = 1'b0; cyc = 0;
            e_addr = '0; e_wdata = '0; e_video = '0; e_rdata = '0;
            exp_q.delete();
        end else if (model_live) begin
            c_slot = tb_phase | bus.video_blank;
            v_slot = !c_slot;
            e_we = 1'b0; e_ack = 1'b0; e_busy = 1'b0;
            if (!act && bus.cpu_req) begin
                act = 1'b1; acc_cyc = cyc; ack_cyc = -1; svc_done = 1'b0;
                m_we = bus.cpu_we; m_addr = bus.cpu_address; m_wdata = bus.cpu_wdata;
            end
            if (v_slot) begin
                e_addr = bus.video_address;
            end else if (act && !svc_done && cyc > acc_cyc) begin
                svc_done = 1'b1;
                e_addr   = m_addr;
                if (m_we) begin
                    e_we = 1'b1; e_wdata = m_wdata; ack_cyc = cyc + 1;
                end else begin
                    exp_q.push_back(exp_mem[m_addr]); ack_cyc = cyc + 2;
                end
            end
            if (act && cyc > acc_cyc && (ack_cyc < 0 || cyc < ack_cyc)) e_busy = 1'b1;
            if (act && cyc == ack_cyc) begin
                e_ack = 1'b1;
                if (!m_we && exp_q.size() > 0) e_rdata = exp_q.pop_front();
            end
            check("mem_address", bus.mem_address, e_addr);
            check("mem_we", bus.mem_we, e_we);
            check("mem_wdata", bus.mem_wdata, e_wdata);
            check("cpu_ack", bus.cpu_ack, e_ack);
            check("cpu_busy", bus.cpu_busy, e_busy);
            check("cpu_rdata", bus.cpu_rdata, e_rdata);
            check("video_data", bus.video_data, e_video);
            if (e_we) exp_mem[e_addr] = e_wdata;
            if (vpend) e_video = vpend_val;
            vpend = v_slot;
            if (v_slot) vpend_val = exp_mem[bus.video_address];
            if (act && cyc == ack_cyc) act = 1'b0;
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    task automatic align_phase(input logic p);
        for (int g = 0; g < 2 && tb_phase != p; g++) tick();
    endtask

    task automatic cpu_xfer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            output int lat, output logic [DW-1:0] rdata, output logic [AW-1:0] addr_at_acc);
        int a0;
        bus.cpu_req     = 1'b1;
        bus.cpu_we      = we;
        bus.cpu_address = addr;
        bus.cpu_wdata   = wdata;
        sample();
        addr_at_acc = bus.mem_address;
        a0    = ack_seen;
        lat   = -1;
        rdata = '0;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            tick();
            if (k == 1) bus.cpu_req = 1'b0;
            sample();
            if (ack_seen != a0) begin
                lat   = k;
                rdata = bus.cpu_rdata;
            end
        end
        checks++;
        if (lat < 0) begin
            failures++;
            $display("FAIL xfer_timeout: no cpu_ack within 8 cycles of request to %0h", addr);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int            lat, a0, w0;
        logic [DW-1:0] rd;
        logic [AW-1:0] acc_addr;

        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 8'(i) ^ 8'hC3;
            exp_mem[i] = 8'(i) ^ 8'hC3;
        end
        ram[14'h0123]     = 8'h5A;
        exp_mem[14'h0123] = 8'h5A;

        reset             = 1'b1;
        bus.video_address = '0;
        bus.video_blank   = 1'b0;
        bus.cpu_req       = 1'b0;
        bus.cpu_we        = 1'b0;
        bus.cpu_address   = '0;
        bus.cpu_wdata     = '0;
        repeat (3) tick();

        // video-only read of 0x0123
        reset             = 1'b0;
        bus.video_address = 14'h0123;
        sample();
        check("reset_phase", phase, 1'b0);
        check("reset_state", state, IDLE);
        check("reset_video_data", bus.video_data, 8'h00);
        check("reset_cpu_rdata", bus.cpu_rdata, 8'h00);
        tick(); tick(); sample();
        check("video_read_5a", bus.video_data, 8'h5A);
        check("video_no_we", we_seen, 0);

        // write 0xA5 to 0x3FFF during active video, accepted in phase 1
        tick();
        w0 = we_seen;
        cpu_xfer(1'b1, 14'h3FFF, 8'hA5, lat, rd, acc_addr);
        check("write_latency", lat, 3);
        check("write_we_count", we_seen - w0, 1);
        check("write_we_addr", last_we_addr, 14'h3FFF);
        check("write_we_phase", last_we_phase, 1'b1);

        // read back 0x3FFF, accepted in phase 1 (worst case)
        tick();
        cpu_xfer(1'b0, 14'h3FFF, 8'h00, lat, rd, acc_addr);
        check("read_latency", lat, 4);
        check("read_data_a5", rd, 8'hA5);
        check("read_video_kept", bus.video_data, 8'h5A);

        // blanking: reads held back-to-back, video slots go to the CPU
        tick();
        align_phase(1'b1);
        a0 = ack_seen;
        bus.video_blank = 1'b1;
        bus.cpu_req     = 1'b1;
        bus.cpu_we      = 1'b0;
        bus.cpu_address = 14'h1234;
        for (int k = 0; k < 16; k++) begin
            sample();
            if (k == 3) check("blank_first_ack", bus.cpu_ack, 1'b1);
            if (k < 15) tick();
        end
        check("blank_ack_count", ack_seen - a0, 4);
        check("blank_read_data", bus.cpu_rdata, 8'hF7);
        tick();
        bus.cpu_req     = 1'b0;
        bus.video_blank = 1'b0;

        // reset while the read sits in READ_WAIT
        tick();
        align_phase(1'b1);
        a0 = ack_seen;
        bus.cpu_req     = 1'b1;
        bus.cpu_we      = 1'b0;
        bus.cpu_address = 14'h0123;
        tick(); bus.cpu_req = 1'b0;
        tick();
        tick(); reset = 1'b1;
        sample();
        check("abort_in_read_wait", state, READ_WAIT);
        check("abort_no_ack", bus.cpu_ack, 1'b0);
        check("abort_no_we", bus.mem_we, 1'b0);
        tick();
        sample();
        check("abort_state_idle", state, IDLE);
        check("abort_phase", phase, 1'b0);
        check("abort_video_data", bus.video_data, 8'h00);
        check("abort_cpu_rdata", bus.cpu_rdata, 8'h00);
        check("abort_busy", bus.cpu_busy, 1'b0);
        check("abort_mem_address", bus.mem_address, 14'h0000);
        check("abort_mem_wdata", bus.mem_wdata, 8'h00);

        // blank falls and cpu_req rises together in phase 0
        tick();
        reset             = 1'b0;
        bus.video_blank   = 1'b1;
        bus.video_address = 14'h0200;
        tick();
        tick();
        check("abort_no_late_ack", ack_seen - a0, 0);
        bus.video_blank = 1'b0;
        cpu_xfer(1'b0, 14'h0123, 8'h00, lat, rd, acc_addr);
        check("simul_video_keeps_slot", acc_addr, 14'h0200);
        check("simul_latency", lat, 3);
        check("simul_read_data", rd, 8'h5A);
        check("simul_video_data", bus.video_data, 8'hC3);

        // held write requests while video_blank toggles, then read back
        tick();
        bus.cpu_req     = 1'b1;
        bus.cpu_we      = 1'b1;
        bus.cpu_address = 14'h0055;
        bus.cpu_wdata   = 8'h3C;
        for (int k = 0; k < 12; k++) begin
            bus.video_blank = (k % 3 == 0);
            tick();
        end
        bus.cpu_req     = 1'b0;
        bus.video_blank = 1'b0;
        repeat (5) tick();
        align_phase(1'b1);
        cpu_xfer(1'b0, 14'h0055, 8'h00, lat, rd, acc_addr);
        check("stream_readback_latency", lat, 4);
        check("stream_readback_data", rd, 8'h3C);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
